video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised VGA display timing generator. It replaces the fixed 640x480 timing block, which needs an external 25 MHz DCM clock. This block runs directly on the 100 MHz system clock, using an internal pixel-enable divider. It produces sync, blanking, raw and scaled pixel coordinates, a frame-start strobe, a frame counter, and a latched vertical-blank interrupt with acknowledge for the PicoBlaze interface. It sits between the system clock and the video controller/colorizer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- CLK_DIV, 4, clocks per pixel (1..16; 1 = every clock)
- SCALE_SHIFT, 2, right shift applied to produce scaled coordinates (0..4)

Ports:
- clock  in  1  system clock (100 MHz); one clock domain. Reset is synchronous, active-high.
- rst  in  1  synchronous active-high reset
- pix_en  out  1  one-clock pulse every CLK_DIV clocks; constant 1 when CLK_DIV=1
- hsync  out  1  horizontal sync, level HS_POL when active
- vsync  out  1  vertical sync, level VS_POL when active
- video_on  out  1  high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
- pixel_column  out  10  current h_cnt
- pixel_row  out  10  current v_cnt
- scaled_column  out  10  pixel_column >> SCALE_SHIFT
- scaled_row  out  10  pixel_row >> SCALE_SHIFT
- frame_start  out  1  one-clock pulse when counters become (0,0)
- frame_count  out  8  frames started since reset; wraps 255 -> 0
- vblank_irq  out  1  latched interrupt, set at vertical-blank entry
- irq_ack  in  1  clears vblank_irq

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; both must be ≤1024. Defaults give 800 and 525.
- Divider counter div runs 0..CLK_DIV-1. pix_en=1 on the clock where div==CLK_DIV-1.
- On a clock with pix_en=1, h_cnt advances:
  - h_cnt==H_TOTAL-1 → h_cnt=0 and v_cnt advances.
  - v_cnt==V_TOTAL-1 → v_cnt=0.
- Line order: active, front porch, sync, back porch (both axes).
- hsync is active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC (defaults: 656..751).
- vsync is active when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC (defaults: 490..491).
- hsync, vsync, video_on and frame_start are flops. They are computed from the next counter values and update on the same edge as the counters, so all outputs stay mutually aligned and glitch-free.
- frame_start=1 for exactly one clock, the clock on which the counters equal (0,0). frame_count increments on that same edge.
- vblank_irq is set on the edge where the counters become (0, V_ACTIVE). It then holds until irq_ack=1 is sampled.
  - irq_ack with vblank_irq=0 has no effect.
  - Set and ack on the same edge: set wins.
- Coordinates during blanking carry raw counter values (≥ H_ACTIVE / ≥ V_ACTIVE); downstream gates them with video_on.

## Timing
- Reset (rst=1 at an edge) forces:
  - div=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1
  - video_on=0, hsync=!HS_POL, vsync=!VS_POL
  - frame_start=0, frame_count=0, vblank_irq=0, pix_en=0 (1 if CLK_DIV=1)
- Reset mid-frame aborts the frame immediately and discards a pending irq.
- After rst deasserts, the first pix_en occurs CLK_DIV clocks later. On that edge the counters become (0,0), frame_start=1, frame_count=1, video_on=1.
- Each pixel lasts exactly CLK_DIV clocks. With defaults, a line is 3200 clocks and a frame is 1,680,000 clocks.
- Scaled outputs are combinational shifts of the registered coordinates, with zero additional latency.
- irq_ack is sampled every clock, independent of pix_en. vblank_irq falls on the edge after ack.

## Test plan
- Reset with defaults: pixel_column=799, pixel_row=524, video_on=0, hsync=vsync=1, vblank_irq=0. Release rst; after 4 clocks → (0,0), frame_start pulses 1 clock, frame_count=1.
- Line timing: measure hsync → low from column 656 through 751, exactly 384 clocks. video_on high for columns 0..639 (2560 clocks) of each of rows 0..479.
- Frame wrap: run 2 full frames → frame_start period 1,680,000 clocks, frame_count=2, vsync low for exactly 2 lines (6400 clocks) starting at row 490.
- Interrupt: at (0,480), vblank_irq=1 and holds with no ack. Pulse irq_ack → cleared next edge. Assert irq_ack continuously across the next set edge → vblank_irq=1 (set wins).
- Variant CLK_DIV=1, HS_POL=1, SCALE_SHIFT=3: pix_en constantly 1, hsync high for 96 clocks, pixel_column=639 → scaled_column=79.
- Mid-frame reset at row 200, column 300, with vblank_irq pending → all reset values restored, irq cleared, frame_count=0, and next frame_start exactly CLK_DIV clocks after release.

Source files
------------

// File: rtl/video_timing_gen.sv
// Parametrised VGA timing generator driven from the system clock through a pixel-enable divider.
// Sync, blanking and strobe outputs are registered from next-state counters so they stay edge-aligned.
`timescale 1ns/1ps
module video_timing_gen #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   CLK_DIV     = 4,
    parameter int   SCALE_SHIFT = 2
) (
    input  logic       clock,
    input  logic       rst,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_column,
    output logic [9:0] pixel_row,
    output logic [9:0] scaled_column,
    output logic [9:0] scaled_row,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       vblank_irq,
    input  logic       irq_ack
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_BLANK_AT = 10'(V_ACTIVE);
    localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);

    // Comparison bounds are one bit wider so a 1024-entry total still fits.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       vblank_q, vblank_d;
    logic       advance;
    logic [10:0] hWide, vWide;

    always_comb begin
        advance = (div_q == DIV_LAST);
        div_d   = advance ? 4'd0 : div_q + 4'd1;

        h_d = h_q;
        v_d = v_q;
        if (advance) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        hWide = {1'b0, h_d};
        vWide = {1'b0, v_d};

        hsync_d    = (hWide >= HS_START && hWide < HS_END) ? HS_POL : ~HS_POL;
        vsync_d    = (vWide >= VS_START && vWide < VS_END) ? VS_POL : ~VS_POL;
        video_on_d = (hWide < H_ACT_END) && (vWide < V_ACT_END);

        // Gated by advance so the strobe lasts one clock even though (0,0) persists CLK_DIV clocks.
        frame_start_d = advance && (h_d == 10'd0) && (v_d == 10'd0);
        frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;

        vblank_d = vblank_q;
        if (advance && (h_d == 10'd0) && (v_d == V_BLANK_AT)) begin
            vblank_d = 1'b1;
        end else if (irq_ack) begin
            vblank_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            div_q         <= 4'd0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            vblank_q      <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            vblank_q      <= vblank_d;
        end
    end

    assign pix_en        = advance;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign video_on      = video_on_q;
    assign pixel_column  = h_q;
    assign pixel_row     = v_q;
    assign scaled_column = h_q >> SCALE_SHIFT;
    assign scaled_row    = v_q >> SCALE_SHIFT;
    assign frame_start   = frame_start_q;
    assign frame_count   = frame_count_q;
    assign vblank_irq    = vblank_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a shrunken-timing instance (16x10, CLK_DIV=4) for frame-level behaviour,
// and a default-geometry CLK_DIV=1 instance for a full line of wide-counter behaviour.
`timescale 1ns/1ps
module tb_video_timing_gen;

    logic       clock = 1'b0;
    logic       rst, rstB, ackA, ackB;
    int         checks = 0;
    int         failures = 0;
    int         t = 0;

    logic       pixEnA, hsyncA, vsyncA, videoOnA, frameStartA, vblankA;
    logic [9:0] colA, rowA, sColA, sRowA;
    logic [7:0] frameCountA;

    logic       pixEnB, hsyncB, vsyncB, videoOnB, frameStartB, vblankB;
    logic [9:0] colB, rowB, sColB, sRowB;
    logic [7:0] frameCountB;

    always #5 clock = ~clock;

    // Small geometry: H 8+2+3+3=16 (hsync cols 10..12), V 6+1+2+1=10 (vsync rows 7..8).
    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(4), .SCALE_SHIFT(1)
    ) dutA (
        .clock(clock), .rst(rst), .pix_en(pixEnA), .hsync(hsyncA), .vsync(vsyncA),
        .video_on(videoOnA), .pixel_column(colA), .pixel_row(rowA),
        .scaled_column(sColA), .scaled_row(sRowA), .frame_start(frameStartA),
        .frame_count(frameCountA), .vblank_irq(vblankA), .irq_ack(ackA)
    );

    video_timing_gen #(
        .HS_POL(1'b1), .CLK_DIV(1), .SCALE_SHIFT(3)
    ) dutB (
        .clock(clock), .rst(rstB), .pix_en(pixEnB), .hsync(hsyncB), .vsync(vsyncB),
        .video_on(videoOnB), .pixel_column(colB), .pixel_row(rowB),
        .scaled_column(sColB), .scaled_row(sRowB), .frame_start(frameStartB),
        .frame_count(frameCountB), .vblank_irq(vblankB), .irq_ack(ackB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks; outputs are sampled on the falling edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge clock);
            t++;
        end
    endtask

    initial begin
        int hsLow, vsLow, vidOn, fsCount, coordErr, firstHsCol, firstVsRow, vbRise;
        int fsFirst, fsSecond, latency, pixEnCount, hsHigh, vidOnB, scaledAt639, firstHsHighCol;

        rst = 1'b1; rstB = 1'b1; ackA = 1'b0; ackB = 1'b0;
        applyStimulus(2);

        checkOutput("rstA_col", colA, 15);
        checkOutput("rstA_row", rowA, 9);
        checkOutput("rstA_video_on", videoOnA, 0);
        checkOutput("rstA_hsync", hsyncA, 1);
        checkOutput("rstA_vsync", vsyncA, 1);
        checkOutput("rstA_vblank", vblankA, 0);
        checkOutput("rstA_frame_count", frameCountA, 0);
        checkOutput("rstA_pix_en", pixEnA, 0);
        checkOutput("rstB_col", colB, 799);
        checkOutput("rstB_row", rowB, 524);
        checkOutput("rstB_hsync", hsyncB, 0);
        checkOutput("rstB_vsync", vsyncB, 1);
        checkOutput("rstB_pix_en", pixEnB, 1);

        rst = 1'b0;
        applyStimulus(3);
        checkOutput("pix_en_third_clock", pixEnA, 1);
        checkOutput("pre_start_col", colA, 15);
        checkOutput("pre_start_frame_start", frameStartA, 0);
        applyStimulus(1);
        t = 0;
        checkOutput("start_col", colA, 0);
        checkOutput("start_row", rowA, 0);
        checkOutput("start_frame_start", frameStartA, 1);
        checkOutput("start_frame_count", frameCountA, 1);
        checkOutput("start_video_on", videoOnA, 1);

        // One whole frame (640 clocks) profiled against the expected raster.
        hsLow = 0; vsLow = 0; vidOn = 0; fsCount = 0; coordErr = 0;
        firstHsCol = -1; firstVsRow = -1; vbRise = -1; fsFirst = -1;
        for (int i = 0; i < 640; i++) begin
            if (colA !== 10'((t / 4) % 16) || rowA !== 10'(t / 64) || sColA !== 10'(((t / 4) % 16) >> 1))
                coordErr++;
            if (hsyncA === 1'b0) begin
                hsLow++;
                if (firstHsCol < 0) firstHsCol = int'(colA);
            end
            if (vsyncA === 1'b0) begin
                vsLow++;
                if (firstVsRow < 0) firstVsRow = int'(rowA);
            end
            if (videoOnA === 1'b1) vidOn++;
            if (frameStartA === 1'b1) begin
                fsCount++;
                if (fsFirst < 0) fsFirst = t;
            end
            if (vblankA === 1'b1 && vbRise < 0) vbRise = t;
            applyStimulus(1);
        end
        checkOutput("coord_errors", coordErr, 0);
        checkOutput("hsync_low_clocks", hsLow, 120);
        checkOutput("hsync_first_col", firstHsCol, 10);
        checkOutput("vsync_low_clocks", vsLow, 128);
        checkOutput("vsync_first_row", firstVsRow, 7);
        checkOutput("video_on_clocks", vidOn, 192);
        checkOutput("frame_start_pulses", fsCount, 1);
        checkOutput("vblank_set_time", vbRise, 384);

        fsSecond = (frameStartA === 1'b1) ? t : -1;
        checkOutput("frame_period", fsSecond - fsFirst, 640);
        checkOutput("frame_count_2", frameCountA, 2);
        checkOutput("wrap_col", colA, 0);
        checkOutput("wrap_row", rowA, 0);
        checkOutput("vblank_held", vblankA, 1);

        ackA = 1'b1;
        applyStimulus(1);
        ackA = 1'b0;
        checkOutput("vblank_acked", vblankA, 0);

        ackA = 1'b1;
        applyStimulus(1023 - t);
        checkOutput("vblank_before_set", vblankA, 0);
        applyStimulus(1);
        checkOutput("vblank_set_wins", vblankA, 1);
        applyStimulus(1);
        checkOutput("vblank_ack_after_set", vblankA, 0);
        ackA = 1'b0;

        applyStimulus(1665 - t);
        checkOutput("vblank_frame3", vblankA, 1);
        applyStimulus(2132 - t);
        checkOutput("mid_col", colA, 5);
        checkOutput("mid_row", rowA, 3);
        checkOutput("mid_vblank_pending", vblankA, 1);
        checkOutput("mid_frame_count", frameCountA, 4);

        rst = 1'b1;
        applyStimulus(1);
        checkOutput("midrst_col", colA, 15);
        checkOutput("midrst_row", rowA, 9);
        checkOutput("midrst_vblank", vblankA, 0);
        checkOutput("midrst_frame_count", frameCountA, 0);
        checkOutput("midrst_video_on", videoOnA, 0);
        checkOutput("midrst_hsync", hsyncA, 1);
        rst = 1'b0;
        latency = -1;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1);
            if (frameStartA === 1'b1) begin
                latency = k;
                break;
            end
        end
        checkOutput("midrst_restart_latency", latency, 4);
        checkOutput("midrst_restart_count", frameCountA, 1);

        // Default geometry, one pixel per clock, active-high hsync.
        rstB = 1'b0;
        applyStimulus(1);
        checkOutput("B_start_col", colB, 0);
        checkOutput("B_start_frame_start", frameStartB, 1);
        pixEnCount = 0; hsHigh = 0; vidOnB = 0; scaledAt639 = -1; firstHsHighCol = -1;
        for (int i = 0; i < 800; i++) begin
            if (pixEnB === 1'b1) pixEnCount++;
            if (hsyncB === 1'b1) begin
                hsHigh++;
                if (firstHsHighCol < 0) firstHsHighCol = int'(colB);
            end
            if (videoOnB === 1'b1) vidOnB++;
            if (colB === 10'd639) scaledAt639 = int'(sColB);
            applyStimulus(1);
        end
        checkOutput("B_pix_en_always", pixEnCount, 800);
        checkOutput("B_hsync_high_clocks", hsHigh, 96);
        checkOutput("B_hsync_first_col", firstHsHighCol, 656);
        checkOutput("B_video_on_clocks", vidOnB, 640);
        checkOutput("B_scaled_col_639", scaledAt639, 79);
        checkOutput("B_row_after_line", rowB, 1);
        checkOutput("B_scaled_row", sRowB, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
